// File: rtl/univ_shift_reg_4b.sv
// ---------------------------------------------------------------------------
// univ_shift_reg_4b
//
// 4-bit universal shift register with single-step and counted-burst operation.
// Operations: shift left, shift right, rotate left, parallel load.
//
// Ports:
//   CLK     in   rising-edge clock
//   RESET   in   asynchronous active-high reset
//   ENB     in   single-step enable (honoured only when idle)
//   MODE    in   00 shl, 01 shr, 10 rotl, 11 load
//   S_IN    in   serial input bit (sampled live, also during a burst)
//   D       in   parallel load data
//   START   in   burst request pulse (sampled only when idle)
//   NSHIFT  in   burst shift count, sampled with START
//   Q       out  register contents
//   S_OUT   out  last bit shifted/rotated out (registered)
//   BUSY    out  high while a burst is running
//   DONE    out  one-cycle pulse after a burst completes
// ---------------------------------------------------------------------------
module univ_shift_reg_4b #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [1:0]       MODE,
    input  logic             S_IN,
    input  logic [WIDTH-1:0] D,
    input  logic             START,
    input  logic [CNT_W-1:0] NSHIFT,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } state_e;

    localparam logic [1:0] ModeShl  = 2'b00;
    localparam logic [1:0] ModeShr  = 2'b01;
    localparam logic [1:0] ModeRotl = 2'b10;
    localparam logic [1:0] ModeLoad = 2'b11;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               s_out_q, s_out_d;

    // One register operation; returns {s_out, q}. An unknown mode holds both.
    function automatic logic [WIDTH:0] step_op(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] cur,
        input logic             sin,
        input logic [WIDTH-1:0] din,
        input logic             sout
    );
        logic [WIDTH:0] res;
        case (m)
            ModeShl:  res = {cur[WIDTH-1], cur[WIDTH-2:0], sin};
            ModeShr:  res = {cur[0], sin, cur[WIDTH-1:1]};
            ModeRotl: res = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
            ModeLoad: res = {sout, din};
            default:  res = {sout, cur};
        endcase
        return res;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        q_d     = q_q;
        s_out_d = s_out_q;

        unique case (state_q)
            StIdle: begin
                // START wins over ENB, except a load request, which never bursts.
                if (START && (MODE != ModeLoad)) begin
                    if (NSHIFT != '0) begin
                        mode_d  = MODE;
                        cnt_d   = NSHIFT;
                        state_d = StRun;
                    end else begin
                        state_d = StFin;
                    end
                end else if (ENB) begin
                    {s_out_d, q_d} = step_op(MODE, q_q, S_IN, D, s_out_q);
                end
            end
            StRun: begin
                {s_out_d, q_d} = step_op(mode_q, q_q, S_IN, D, s_out_q);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= ModeShl;
            q_q     <= '0;
            s_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            s_out_q <= s_out_d;
        end
    end

    // Status decoded from the state register, so reset clears it immediately.
    assign Q     = q_q;
    assign S_OUT = s_out_q;
    assign BUSY  = (state_q == StRun);
    assign DONE  = (state_q == StFin);

endmodule
